// File: rtl/pc_unit_ras.sv
// ---------------------------------------------------------------------------
// pc_unit_ras
//   Program counter for the CNT core fetch stage. It supports stall, branch,
//   call and return. Return addresses are kept in an internal circular
//   return-address stack (RAS).
//
//   Priority per cycle: rst > stall > ret > call > br_taken > sequential.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous, active-high reset
//   stall      : hold pc, RAS and flags; all other requests are ignored
//   br_taken   : jump to target
//   call       : push pc+1 onto the RAS, then jump to target
//   ret        : pop the RAS top into pc (nop plus ras_unf when the RAS is empty)
//   target     : branch/call destination
//   pc         : current fetch address (registered)
//   pc_plus_1  : combinational pc+1, wrapping modulo 2**PC_W
//   ras_count  : number of valid RAS entries (0..RAS_DEPTH)
//   ras_ovf    : sticky, set when a call finds the RAS full
//   ras_unf    : sticky, set when a ret finds the RAS empty
// ---------------------------------------------------------------------------
module pc_unit_ras #(
    parameter int unsigned PC_W      = 8,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         br_taken,
    input  logic                         call,
    input  logic                         ret,
    input  logic [PC_W-1:0]              target,
    output logic [PC_W-1:0]              pc,
    output logic [PC_W-1:0]              pc_plus_1,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  pc_r;
    logic [CNT_W-1:0] cnt_r;
    // ptr_r is the next slot to write. The top of stack is at ptr_r-1.
    logic [PTR_W-1:0] ptr_r;
    logic             ovf_r;
    logic             unf_r;
    logic [PC_W-1:0]  ras_mem_r [RAS_DEPTH];

    logic [PC_W-1:0]  pc_plus_1_s;
    logic [PTR_W-1:0] top_idx_s;
    logic             ras_empty_s;
    logic             ras_full_s;
    logic [PC_W-1:0]  pc_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [PTR_W-1:0] ptr_nxt_s;
    logic             ovf_nxt_s;
    logic             unf_nxt_s;
    logic             push_s;

    assign pc_plus_1_s = pc_r + PC_W'(1);
    assign top_idx_s   = ptr_r - PTR_W'(1);
    assign ras_empty_s = (cnt_r == CNT_W'(0));
    assign ras_full_s  = (cnt_r == CNT_W'(RAS_DEPTH));

    assign pc        = pc_r;
    assign pc_plus_1 = pc_plus_1_s;
    assign ras_count = cnt_r;
    assign ras_ovf   = ovf_r;
    assign ras_unf   = unf_r;

    // Next-state selection for pc, stack pointer, count and sticky flags.
    always_comb begin
        pc_nxt_s  = pc_r;
        cnt_nxt_s = cnt_r;
        ptr_nxt_s = ptr_r;
        ovf_nxt_s = ovf_r;
        unf_nxt_s = unf_r;
        push_s    = 1'b0;
        if (stall) begin
            pc_nxt_s = pc_r;
        end else if (ret) begin
            // A simultaneous call is dropped: ret has priority.
            if (ras_empty_s) begin
                pc_nxt_s  = pc_plus_1_s;
                unf_nxt_s = 1'b1;
            end else begin
                pc_nxt_s  = ras_mem_r[top_idx_s];
                cnt_nxt_s = cnt_r - CNT_W'(1);
                ptr_nxt_s = top_idx_s;
            end
        end else if (call) begin
            // On a full RAS the pointer wraps onto the oldest entry, which
            // is overwritten. The count then saturates at RAS_DEPTH.
            push_s    = 1'b1;
            pc_nxt_s  = target;
            ptr_nxt_s = ptr_r + PTR_W'(1);
            if (ras_full_s) begin
                ovf_nxt_s = 1'b1;
            end else begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
            end
        end else if (br_taken) begin
            pc_nxt_s = target;
        end else begin
            pc_nxt_s = pc_plus_1_s;
        end
    end

    // Control state registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r  <= PC_W'(RESET_PC);
            cnt_r <= CNT_W'(0);
            ptr_r <= PTR_W'(0);
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            pc_r  <= pc_nxt_s;
            cnt_r <= cnt_nxt_s;
            ptr_r <= ptr_nxt_s;
            ovf_r <= ovf_nxt_s;
            unf_r <= unf_nxt_s;
        end
    end

    // Return-address storage. Contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            ras_mem_r[ptr_r] <= pc_plus_1_s;
        end else begin
            ras_mem_r[ptr_r] <= ras_mem_r[ptr_r];
        end
    end

endmodule
